// File: rtl/ram_sdp_be.sv
// ---------------------------------------------------------------------------
// ram_sdp_be: simple dual-port RAM with per-byte write enables.
//   After reset the array is cleared one word per cycle, starting at address 0
//   (INIT state). The RUN state then serves writes and pipelined reads.
//   init_done goes high when the clear is finished.
//
// Parameters
//   DATA_WIDTH  word width in bits; must be a multiple of 8
//   ADDR_WIDTH  address width in bits
//   RAM_DEPTH   number of words (default 1 << ADDR_WIDTH)
//   RD_LATENCY  read latency in cycles; only 1 or 2 is legal
//
// Ports
//   clk        sole clock; all logic runs on its rising edge
//   rst_n      asynchronous active-low reset
//   wr_en      write request (ignored during INIT)
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte enables; bit i covers wr_data[8i+7:8i]
//   rd_en      read request (ignored during INIT)
//   rd_addr    read address
//   rd_data    registered read data; holds its value between reads
//   rd_valid   one-cycle pulse for each completed read
//   init_done  high from the first RUN cycle until the next reset
//
// Build option
//   RAM_SDP_FWD_EN  when defined, a read and a write to the same address in
//                   the same cycle return the merged word (write-first).
//                   When undefined, the read returns the old word
//                   (read-first). The write takes effect in both builds.
// ---------------------------------------------------------------------------
module ram_sdp_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic                    run_c;
  logic                    rd_fire_c;
  logic [DATA_WIDTH-1:0]   be_mask_c;
  logic [DATA_WIDTH-1:0]   wr_merged_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_data;

  // Reject illegal configurations at elaboration.
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8");
  end

  // State and clear counter; init_done rises on the edge that clears the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + ADDR_ONE;
      if (clr_cnt == LAST_ADDR) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  assign run_c     = (state == ST_RUN);
  assign rd_fire_c = run_c & rd_en;

  // Expand byte enables to a bit mask.
  for (genvar gb = 0; gb < BE_WIDTH; gb++) begin : g_be_mask
    assign be_mask_c[8*gb +: 8] = {8{wr_be[gb]}};
  end

  assign wr_merged_c = (mem[wr_addr] & ~be_mask_c) | (wr_data & be_mask_c);

  // Storage: zero-fill during INIT, byte-masked writes during RUN.
  always_ff @(posedge clk) begin
    if (!run_c) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_merged_c;
    end
  end

  // Word presented to the read pipeline; collision handling depends on build.
  always_comb begin
    rd_word_c = mem[rd_addr];
`ifdef RAM_SDP_FWD_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_word_c = wr_merged_c;
    end
`else
    rd_word_c = mem[rd_addr];
`endif
  end

  // First read stage; data only loads on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire_c;
      if (rd_fire_c) begin
        s1_data <= rd_word_c;
      end
    end
  end

  // Output stage selection by read latency.
  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_data  = s1_data;
    assign rd_valid = s1_valid;
  end else if (RD_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= s1_valid;
        if (s1_valid) begin
          rd_data <= s1_data;
        end
      end
    end
  end else begin : g_bad_latency
    $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_be: self-checking bench for ram_sdp_be. Two instances (read
// latency 1 and 2, ADDR_WIDTH 4) share one stimulus stream and are compared
// every cycle against a behavioural model: a reference word array, the clear
// sequence as a simple count, and a per-cycle history of accepted reads.
// ---------------------------------------------------------------------------
module tb_ram_sdp_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HIST  = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          init_done1, init_done2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_run;
  int            m_cnt;
  int            cyc;
  bit            hv [HIST];
  logic [DW-1:0] hd [HIST];
  logic [DW-1:0] last1, last2;

  always #5 clk = ~clk;

  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_done(init_done1)
  );

  ram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .init_done(init_done2)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit ev2;
    ev2 = (cyc > 0) ? hv[cyc-1] : 1'b0;
    check({tag, "/init_done_l1"}, DW'(init_done1), DW'(m_run));
    check({tag, "/init_done_l2"}, DW'(init_done2), DW'(m_run));
    check({tag, "/rd_valid_l1"}, DW'(rd_valid1), DW'(hv[cyc]));
    check({tag, "/rd_valid_l2"}, DW'(rd_valid2), DW'(ev2));
    check({tag, "/rd_data_l1"}, rd_data1, last1);
    check({tag, "/rd_data_l2"}, rd_data2, last2);
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // then compare shortly after the edge.
  task automatic tick(input string tag);
    logic [DW-1:0] v;
    @(posedge clk);
    cyc++;
    if (cyc >= int'(HIST)) begin
      $display("FAIL history_overflow: observed cycle %0d required below %0d", cyc, HIST);
      $fatal(1, "history overflow");
    end
    hv[cyc] = 1'b0;
    if (rst_n) begin
      if (!m_run) begin
        ref_mem[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == int'(DEPTH)) m_run = 1'b1;
      end else begin
        if (rd_en) begin
          v = ref_mem[rd_addr];
`ifdef RAM_SDP_FWD_EN
          if (wr_en && wr_addr == rd_addr) v = merge(v, wr_data, wr_be);
`endif
          hv[cyc] = 1'b1;
          hd[cyc] = v;
        end
        if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
      end
    end
    if (hv[cyc]) last1 = hd[cyc];
    if (hv[cyc-1]) last2 = hd[cyc-1];
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    last1 = '0;
    last2 = '0;
    hv[cyc] = 1'b0;
    if (cyc > 0) hv[cyc-1] = 1'b0;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_be = '0;
  endtask

  task automatic junk();
    wr_en   = 1'($urandom_range(0, 1));
    rd_en   = 1'($urandom_range(0, 1));
    wr_addr = AW'($urandom_range(0, DEPTH - 1));
    rd_addr = AW'($urandom_range(0, DEPTH - 1));
    wr_data = $urandom;
    wr_be   = 4'($urandom_range(0, 15));
  endtask

  task automatic write(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be; rd_en = 1'b0;
  endtask

  logic [DW-1:0] coll_exp;

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0;
    wr_data = '0; wr_be = '0;
    cyc = 0; m_run = 1'b0; m_cnt = 0; last1 = '0; last2 = '0;
    foreach (hv[i]) hv[i] = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
`ifdef RAM_SDP_FWD_EN
    coll_exp = 32'hAAAA5555;
`else
    coll_exp = 32'hAAAAAAAA;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_outputs("reset");
    tick("in_reset");
    tick("in_reset");
    rst_n = 1'b1;

    // Clear phase with random requests that must be ignored
    for (int i = 0; i < int'(DEPTH); i++) begin
      junk();
      tick("init");
    end
    check("init_done_after_16", DW'(init_done1), 32'd1);
    idle();

    // Every word reads zero after the clear
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick("read_zero");
    end
    idle(); tick("drain"); tick("drain");

    // Byte-enable merge
    write(3, 32'hDEADBEEF, 4'b1111); tick("be_full");
    write(3, 32'h11223344, 4'b0101); tick("be_partial");
    idle(); rd_en = 1'b1; rd_addr = AW'(3); tick("be_read");
    check("be_merge_l1", rd_data1, 32'hDE22BE44);
    idle(); tick("be_drain");
    check("be_merge_l2", rd_data2, 32'hDE22BE44);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      write(i, 32'(32'hA0 + i), 4'b1111);
      tick("burst_fill");
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick("burst_read");
      if (i > 0) begin
        check("burst_l2_valid", DW'(rd_valid2), 32'd1);
        check("burst_l2_data", rd_data2, 32'(32'hA0 + i - 1));
      end
    end
    idle(); tick("burst_tail");
    check("burst_l2_last", rd_data2, 32'hA3);
    tick("burst_hold");
    check("hold_l1", rd_data1, 32'hA3);

    // Same-address collision
    write(5, 32'hAAAAAAAA, 4'b1111); tick("coll_prep");
    write(5, 32'h55555555, 4'b0011); rd_en = 1'b1; rd_addr = AW'(5);
    tick("coll");
    check("coll_l1", rd_data1, coll_exp);
    idle(); rd_en = 1'b1; rd_addr = AW'(5);
    tick("coll_next");
    check("coll_l2", rd_data2, coll_exp);
    check("after_coll_l1", rd_data1, 32'hAAAA5555);
    idle(); tick("coll_drain");
    check("after_coll_l2", rd_data2, 32'hAAAA5555);

    // Random traffic with frequent same-address pairs
    for (int i = 0; i < 300; i++) begin
      junk();
      if ($urandom_range(0, 2) == 0) rd_addr = wr_addr;
      tick("random");
    end
    idle(); tick("rand_drain"); tick("rand_drain");

    // Reset while a read is in flight
    write(7, 32'hCAFEF00D, 4'b1111); tick("flight_prep");
    idle(); rd_en = 1'b1; rd_addr = AW'(7); tick("flight_read");
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check("async_rd_valid_l1", DW'(rd_valid1), 32'd0);
    check("async_rd_data_l1", rd_data1, 32'd0);
    tick("held_reset");
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      junk();
      tick("reinit");
    end
    idle();
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick("reread_zero");
    end
    idle(); tick("final"); tick("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
RAM_SDP_BE -- requirements
Module: ram_sdp_be

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, read/write data width in bits; multiple of 8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 SHALL provide parameter RAM_DEPTH, default 1 << ADDR_WIDTH, number of words.
REQ-004 SHALL provide parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 SHALL provide port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port wr_en  input  1  write request.
REQ-008 SHALL provide port wr_addr  input  ADDR_WIDTH  write address.
REQ-009 SHALL provide port wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL provide port wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 SHALL provide port rd_en  input  1  read request.
REQ-012 SHALL provide port rd_addr  input  ADDR_WIDTH  read address.
REQ-013 SHALL provide port rd_data  output  DATA_WIDTH  read data, registered.
REQ-014 SHALL provide port rd_valid  output  1  one-cycle pulse per completed read.
REQ-015 SHALL provide port init_done  output  1  high once memory clear is complete.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN; reset enters INIT with clear counter = 0.
REQ-017 In INIT, SHALL write all-zero to mem[counter] each cycle and increment counter.
REQ-018 SHALL move INIT->RUN on the cycle that writes address RAM_DEPTH-1; INIT lasts exactly RAM_DEPTH cycles.
REQ-019 init_done SHALL be registered, low in INIT, high from the first RUN cycle until next reset.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored; rd_valid SHALL stay 0.
REQ-021 In RUN, wr_en=1 SHALL update only bytes of mem[wr_addr] whose wr_be bit is 1; wr_be=0 is a no-op.
REQ-022 In RUN, rd_en=1 at edge N SHALL produce rd_data = mem[rd_addr] and rd_valid=1 after edge N+RD_LATENCY-1 (visible RD_LATENCY cycles later).
REQ-023 Reads SHALL be fully pipelined: rd_en every cycle yields rd_valid every cycle after the latency.
REQ-024 rd_data SHALL hold its last value when no read completes; rd_valid SHALL be 0 in such cycles.
REQ-025 Same-cycle write and read to different addresses SHALL both complete independently.
REQ-026 Same-cycle write and read to the same address: behaviour per REQ-033/REQ-034.
REQ-027 RD_LATENCY=2 SHALL add one output register stage carrying both rd_data and rd_valid.
REQ-028 RD_LATENCY outside {1,2} SHALL fail elaboration.
REQ-029 Addresses SHALL use the full ADDR_WIDTH range without wrap logic; addresses >= RAM_DEPTH are unsupported.

Reset
REQ-030 rst_n low SHALL asynchronously force rd_data=0, rd_valid=0, init_done=0, FSM=INIT, counter=0, and flush read pipeline stages.
REQ-031 Reset asserted mid-INIT or mid-read SHALL abort the operation; no rd_valid pulse for in-flight reads after reset.
REQ-032 After rst_n release, the clear SHALL restart at address 0; prior contents are zeroed, never read out.

Configuration
REQ-033 Macro RAM_SDP_FWD_EN defined: same-address collision in RUN SHALL return merged data: wr_be-enabled bytes from wr_data, remaining bytes from old memory (write-first).
REQ-034 Macro RAM_SDP_FWD_EN undefined: same-address collision SHALL return the full old memory word (read-first); write still takes effect.

Verification
REQ-035 Reset release with ADDR_WIDTH=4 -> init_done rises exactly 16 cycles later; reads of addresses 0..15 return 0x00000000.
REQ-036 Write addr 3 data 0xDEADBEEF be 4'b1111, then write addr 3 data 0x11223344 be 4'b0101 -> read addr 3 returns 0xDE22BE44.
REQ-037 RD_LATENCY=2, rd_en for 4 consecutive cycles on addresses 0..3 holding 0xA0..0xA3 -> rd_valid high 4 consecutive cycles starting 2 cycles later, data 0xA0..0xA3 in order.
REQ-038 mem[5]=0xAAAAAAAA; same cycle write addr 5 data 0x55555555 be 4'b0011 and read addr 5 -> 0xAAAA5555 with RAM_SDP_FWD_EN, 0xAAAAAAAA without; next read gives 0xAAAA5555 in both builds.
REQ-039 rd_en and wr_en asserted during INIT -> rd_valid stays 0, memory remains all-zero after init_done.
REQ-040 rst_n pulsed low while a read is in flight in RUN -> rd_valid=0, rd_data=0 immediately; init_done low; clear restarts and all words read 0 afterwards.
